// File: rtl/alu_rom_sliced.sv
// alu_rom_sliced: multi-cycle ALU that walks SLICE-bit operand slices through
// one external ROM, carrying the X/carry cascade in registers between lookups.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, op, fl, x_in   request and operation/cascade-in, latched at accept
//   a, b                  WIDTH-bit operands, latched at accept
//   rom_a, rom_d          registered ROM address {idx, op, x, c, b_s, a_s}, ROM data
//   busy, done            operation in progress, one-cycle completion pulse
//   nromoe, ibus          active-low IBus enable, tri-state result bus
//   fvout_rom/nsetv_rom   V flag value and active-low write strobe
//   flout_rom/nsetl_rom   L flag value and active-low write strobe
module alu_rom_sliced #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned SLICE    = 6,
   parameter int unsigned ROM_WAIT = 1,
   parameter int unsigned IW       = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [2:0]                op,
   input  logic                      fl,
   input  logic                      x_in,
   input  logic [WIDTH-1:0]          a,
   input  logic [WIDTH-1:0]          b,
   output logic [IW+4+2*SLICE:0]     rom_a,
   input  logic [SLICE+1:0]          rom_d,
   output logic                      busy,
   output logic                      done,
   input  logic                      nromoe,
   output logic [WIDTH-1:0]          ibus,
   output logic                      fvout_rom,
   output logic                      nsetv_rom,
   output logic                      flout_rom,
   output logic                      nsetl_rom
);
   localparam int unsigned NS = (WIDTH + SLICE - 1) / SLICE;
   localparam int unsigned LW = WIDTH - SLICE * (NS - 1);
   localparam int unsigned PW = NS * SLICE;
   localparam int unsigned AW = IW + 5 + 2 * SLICE;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_LOOK, S_FIN} state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic              x_q, x_d, c_q, c_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic [AW-1:0]     rom_a_q, rom_a_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              fv_q, fv_d, nsv_q, nsv_d, fl_q, fl_d, nsl_q, nsl_d;

   // Operand slice k, zero-padded past the top of the operand.
   function automatic logic [SLICE-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                 input logic [IW-1:0]    k);
      return SLICE'(PW'(v) >> (32'(k) * SLICE));
   endfunction

   function automatic logic [AW-1:0] addr_of(input logic [IW-1:0]    k,
                                             input logic [2:0]       o,
                                             input logic             xx,
                                             input logic             cc,
                                             input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv);
      return {k, o, xx, cc, slice_of(bv, k), slice_of(av, k)};
   endfunction

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      x_d     = x_q;
      c_d     = c_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      rom_a_d = rom_a_q;
      y_d     = y_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      fv_d    = fv_q;
      nsv_d   = nsv_q;
      fl_d    = fl_q;
      nsl_d   = nsl_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               x_d     = x_in;
               c_d     = fl;
               idx_d   = '0;
               wcnt_d  = '0;
               rom_a_d = addr_of('0, op, x_in, fl, a, b);
               busy_d  = 1'b1;
               state_d = S_LOOK;
            end
         end
         S_LOOK: begin
            if (wcnt_q != CW'(ROM_WAIT)) begin
               wcnt_d = wcnt_q + CW'(1);
            end else if (idx_q != IW'(NS - 1)) begin
               // Intermediate slice: capture cascade and result slice, present next address.
               x_d     = rom_d[SLICE+1];
               c_d     = rom_d[SLICE];
               y_d     = (y_q & ~(WIDTH'({SLICE{1'b1}}) << (32'(idx_q) * SLICE)))
                       | (WIDTH'(rom_d[SLICE-1:0]) << (32'(idx_q) * SLICE));
               idx_d   = idx_q + IW'(1);
               wcnt_d  = '0;
               rom_a_d = addr_of(idx_d, op_q, x_d, c_d, a_q, b_q);
            end else begin
               // Final slice: top result bits plus the flag values and strobes.
               {nsl_d, fl_d, nsv_d, fv_d} = rom_d[LW+3:LW];
               y_d[WIDTH-1 -: LW]         = rom_d[LW-1:0];
               busy_d                     = 1'b0;
               done_d                     = 1'b1;
               state_d                    = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         x_q     <= 1'b0;
         c_q     <= 1'b0;
         idx_q   <= '0;
         wcnt_q  <= '0;
         rom_a_q <= '0;
         y_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fv_q    <= 1'b0;
         nsv_q   <= 1'b1;
         fl_q    <= 1'b0;
         nsl_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         x_q     <= x_d;
         c_q     <= c_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         rom_a_q <= rom_a_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fv_q    <= fv_d;
         nsv_q   <= nsv_d;
         fl_q    <= fl_d;
         nsl_q   <= nsl_d;
      end
   end

   assign rom_a     = rom_a_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fvout_rom = fv_q;
   assign nsetv_rom = nsv_q;
   assign flout_rom = fl_q;
   assign nsetl_rom = nsl_q;

   // IBus driver: only the output enable and the result register feed it.
   assign ibus = nromoe ? {WIDTH{1'bz}} : y_q;

endmodule

// File: tb/tb_alu_rom_sliced.sv
// Bench for alu_rom_sliced: three instances (ROM_WAIT 1/0/3) on shared
// stimulus, each fed by a slice-level ADD ROM model; results are compared
// against whole-word arithmetic.
module tb_alu_rom_sliced;
   logic        clk = 1'b0;
   logic        reset, start, fl, x_in, nromoe;
   logic [2:0]  op;
   logic [15:0] a, b;
   logic [18:0] rom_a1, rom_a0, rom_a3;
   logic [7:0]  rom_d1, rom_d0, rom_d3;
   logic        busy1, busy0, busy3, done1, done0, done3;
   tri1  [15:0] ibus1;
   wire  [15:0] ibus0, ibus3;
   logic        fv1, nv1, fo1, nl1, fv0, nv0, fo0, nl0, fv3, nv3, fo3, nl3;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // External ROM: op 0 is a slice adder, other ops read as zero with strobes high.
   function automatic logic [7:0] rom_model(input logic [18:0] ad);
      logic [6:0] s;
      logic [4:0] t;
      if (ad[16:14] != 3'd0) return (ad[18:17] == 2'd2) ? 8'hA0 : 8'h00;
      if (ad[18:17] != 2'd2) begin
         s = 7'(ad[5:0]) + 7'(ad[11:6]) + 7'(ad[12]);
         return {ad[13], s[6], s[5:0]};
      end
      t = 5'(ad[3:0]) + 5'(ad[9:6]) + 5'(ad[12]);
      return {1'b0, t[4], 1'b0, (ad[3] == ad[9]) && (t[3] != ad[3]), t[3:0]};
   endfunction

   assign rom_d1 = rom_model(rom_a1);
   assign rom_d0 = rom_model(rom_a0);
   assign rom_d3 = rom_model(rom_a3);

   alu_rom_sliced u_dut (.clk(clk), .reset(reset), .start(start), .op(op), .fl(fl),
      .x_in(x_in), .a(a), .b(b), .rom_a(rom_a1), .rom_d(rom_d1), .busy(busy1),
      .done(done1), .nromoe(nromoe), .ibus(ibus1), .fvout_rom(fv1), .nsetv_rom(nv1),
      .flout_rom(fo1), .nsetl_rom(nl1));
   alu_rom_sliced #(.ROM_WAIT(0)) u_w0 (.clk(clk), .reset(reset), .start(start), .op(op),
      .fl(fl), .x_in(x_in), .a(a), .b(b), .rom_a(rom_a0), .rom_d(rom_d0), .busy(busy0),
      .done(done0), .nromoe(nromoe), .ibus(ibus0), .fvout_rom(fv0), .nsetv_rom(nv0),
      .flout_rom(fo0), .nsetl_rom(nl0));
   alu_rom_sliced #(.ROM_WAIT(3)) u_w3 (.clk(clk), .reset(reset), .start(start), .op(op),
      .fl(fl), .x_in(x_in), .a(a), .b(b), .rom_a(rom_a3), .rom_d(rom_d3), .busy(busy3),
      .done(done3), .nromoe(nromoe), .ibus(ibus3), .fvout_rom(fv3), .nsetv_rom(nv3),
      .flout_rom(fo3), .nsetl_rom(nl3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] ref_sum(input logic [2:0] o, input logic [15:0] av,
                                           input logic [15:0] bv, input logic f);
      if (o != 3'd0) return 17'd0;
      return 17'(av) + 17'(bv) + 17'(f);
   endfunction

   task automatic check_result(input string tag, input logic [2:0] o, input logic [15:0] av,
                               input logic [15:0] bv, input logic f);
      logic [16:0] s;
      logic        ev;
      s  = ref_sum(o, av, bv, f);
      ev = (o == 3'd0) && (av[15] == bv[15]) && (s[15] != av[15]);
      nromoe = 1'b0;
      #1;
      chk({tag, ":y"},     32'(ibus1), 32'(s[15:0]));
      chk({tag, ":flout"}, 32'(fo1),   32'(s[16]));
      chk({tag, ":fvout"}, 32'(fv1),   32'(ev));
      chk({tag, ":nsetl"}, 32'(nl1),   32'(o != 3'd0));
      chk({tag, ":nsetv"}, 32'(nv1),   32'(o != 3'd0));
   endtask

   // One idle cycle, accept, scramble inputs, then wait for done on the main instance.
   task automatic do_op(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic f, output int lat, output logic [18:0] ra2,
                        output logic [18:0] ra4);
      start = 1'b0;
      tick();
      op = o; a = av; b = bv; fl = f; start = 1'b1;
      tick();
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); fl = 1'($urandom); op = 3'($urandom);
      lat = -1; ra2 = '0; ra4 = '0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (n == 2) ra2 = rom_a1;
         if (n == 4) ra4 = rom_a1;
         nromoe = 1'($urandom);
         if (done1) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int          lat, l1, l0, l3, cnt, first, second;
      logic [18:0] ra2, ra4, held;
      logic [2:0]  ro;
      logic [15:0] ra, rb;
      logic        rf;

      reset = 1'b1; start = 1'b0; op = '0; fl = 1'b0; x_in = 1'b0; nromoe = 1'b1;
      a = '0; b = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst:busy", 32'(busy1), 32'd0);
      chk("rst:done", 32'(done1), 32'd0);
      chk("rst:ibus_off", 32'((ibus1 === 16'hzzzz) || (ibus1 === 16'hffff)), 32'd1);
      nromoe = 1'b0;
      #1;
      chk("rst:ibus_on", 32'(ibus1), 32'h0000);
      chk("rst:nsetl", 32'(nl1), 32'd1);
      chk("rst:nsetv", 32'(nv1), 32'd1);
      chk("rst:flags", 32'({fo1, fv1}), 32'd0);
      chk("rst:rom_a", 32'(rom_a1), 32'd0);

      // Latency and slice walk for ROM_WAIT 1, 0 and 3 side by side.
      op = 3'd0; a = 16'hABCD; b = 16'h1357; fl = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      l1 = -1; l0 = -1; l3 = -1; held = '0;
      for (int n = 0; n <= 13; n++) begin
         if (n > 0) tick();
         if (n < 3)  chk("w0:idx", 32'(rom_a0[18:17]), 32'(n));
         if (n < 12) begin
            chk("w3:idx", 32'(rom_a3[18:17]), 32'(n / 4));
            if (n % 4 == 0) held = rom_a3;
            else chk("w3:stable", 32'(rom_a3), 32'(held));
         end
         if (n < 6) chk("w1:idx", 32'(rom_a1[18:17]), 32'(n / 2));
         if (done1 && l1 < 0) l1 = n;
         if (done0 && l0 < 0) l0 = n;
         if (done3 && l3 < 0) l3 = n;
      end
      chk("lat:w1", 32'(l1), 32'd6);
      chk("lat:w0", 32'(l0), 32'd3);
      chk("lat:w3", 32'(l3), 32'd12);
      nromoe = 1'b0;
      #1;
      chk("w0:y", 32'(ibus0), 32'(16'hABCD + 16'h1357 + 16'd1));
      chk("w3:y", 32'(ibus3), 32'(16'hABCD + 16'h1357 + 16'd1));
      check_result("w1", 3'd0, 16'hABCD, 16'h1357, 1'b1);

      // Carry ripple through every slice.
      do_op(3'd0, 16'h0001, 16'hFFFF, 1'b0, lat, ra2, ra4);
      chk("ripple:lat", 32'(lat), 32'd6);
      chk("ripple:idx1", 32'(ra2[18:17]), 32'd1);
      chk("ripple:c1", 32'(ra2[12]), 32'd1);
      chk("ripple:idx2", 32'(ra4[18:17]), 32'd2);
      chk("ripple:c2", 32'(ra4[12]), 32'd1);
      check_result("ripple", 3'd0, 16'h0001, 16'hFFFF, 1'b0);

      do_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, lat, ra2, ra4);
      chk("ovf:lat", 32'(lat), 32'd6);
      check_result("ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b0);
      do_op(3'd0, 16'h0000, 16'h0000, 1'b1, lat, ra2, ra4);
      check_result("cin", 3'd0, 16'h0000, 16'h0000, 1'b1);

      // Start pulsed during LOOK is ignored.
      tick();
      op = 3'd0; a = 16'h1111; b = 16'h2222; fl = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; fl = 1'b1;
      tick();
      start = 1'b0;
      lat = -1;
      for (int n = 4; n <= 40; n++) begin
         tick();
         if (done1) begin
            lat = n;
            break;
         end
      end
      chk("look_start:lat", 32'(lat), 32'd6);
      check_result("look_start", 3'd0, 16'h1111, 16'h2222, 1'b0);
      cnt = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (done1) cnt++;
      end
      chk("look_start:extra_done", 32'(cnt), 32'd0);
      chk("look_start:busy", 32'(busy1), 32'd0);

      // Start held high: back-to-back operations, one done each.
      op = 3'd0; a = 16'h00FF; b = 16'h0101; fl = 1'b0; start = 1'b1;
      tick();
      cnt = 0; first = -1; second = -1;
      for (int n = 1; n <= 14; n++) begin
         tick();
         if (done1) begin
            cnt++;
            if (first < 0) first = n;
            else second = n;
         end
      end
      start = 1'b0;
      chk("held:count", 32'(cnt), 32'd2);
      chk("held:first", 32'(first), 32'd6);
      chk("held:second", 32'(second), 32'd14);
      check_result("held", 3'd0, 16'h00FF, 16'h0101, 1'b0);
      cnt = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (done1 || busy1) cnt++;
      end
      chk("held:quiet", 32'(cnt), 32'd0);

      // Reset in the middle of an operation.
      op = 3'd0; a = 16'h4321; b = 16'h1111; fl = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("midrst:idx", 32'(rom_a1[18:17]), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      nromoe = 1'b0;
      #1;
      chk("midrst:busy", 32'(busy1), 32'd0);
      chk("midrst:done", 32'(done1), 32'd0);
      chk("midrst:y", 32'(ibus1), 32'd0);
      chk("midrst:rom_a", 32'(rom_a1), 32'd0);
      cnt = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (done1) cnt++;
      end
      chk("midrst:no_done", 32'(cnt), 32'd0);
      do_op(3'd0, 16'h1234, 16'h0001, 1'b0, lat, ra2, ra4);
      chk("after_rst:lat", 32'(lat), 32'd6);
      check_result("after_rst", 3'd0, 16'h1234, 16'h0001, 1'b0);

      // Random operations against whole-word arithmetic.
      for (int i = 0; i < 24; i++) begin
         ro = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rf = 1'($urandom);
         do_op(ro, ra, rb, rf, lat, ra2, ra4);
         chk("rand:lat", 32'(lat), 32'd6);
         check_result("rand", ro, ra, rb, rf);
      end
      nromoe = 1'b1;
      #1;
      chk("final:ibus_off", 32'((ibus1 === 16'hzzzz) || (ibus1 === 16'hffff)), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
